mips_perf_mon: RTL and testbench

Synthesizable performance monitor and run-termination detector for the pipelined MIPS core. It counts total cycles, stall cycles and N generic event channels. It detects the "finish" store (write-enable with a configurable data address) and captures the stored word, and it flags a timeout after a configurable cycle budget. It sits beside `mipse` on the data-memory bus and replaces ad-hoc bench counting, so the same measurements are available in simulation and on FPGA.

---
 rtl/mips_perf_mon_if.sv | 15 +
 rtl/mips_perf_mon.sv | 112 +++++++++++
 tb/tb_mips_perf_mon.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_perf_mon_if.sv
// Data-memory side bus observed by the performance monitor.
// The core (or a bench) drives it, and the monitor only listens.
interface mips_perf_mon_if #(
  parameter int DATA_W = 32,
  parameter int N_EV   = 4
);
  logic              stall;
  logic [N_EV-1:0]   ev;
  logic [DATA_W-1:0] daddr;
  logic              we;
  logic [DATA_W-1:0] wdata;

  modport master (output stall, ev, daddr, we, wdata);
  modport slave  (input  stall, ev, daddr, we, wdata);
endinterface

// File: rtl/mips_perf_mon.sv
// Cycle/stall/event counters with finish-store and cycle-budget run termination.
// All counters saturate, and they freeze once the run ends until clr or reset.
module mips_perf_mon #(
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                N_EV        = 4,
  parameter logic [DATA_W-1:0] FINISH_ADDR = DATA_W'(100),
  parameter int unsigned       MAX_CYCLES  = 100000,
  parameter int                SEL_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [SEL_W-1:0]   rd_sel,
  mips_perf_mon_if.slave     bus,
  output logic [CNT_W-1:0]   rd_data,
  output logic               done,
  output logic               timeout,
  output logic               done_pulse,
  output logic [DATA_W-1:0]  result
);

  localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stl_q;
  logic [CNT_W-1:0] ev_q  [N_EV];

  logic [CNT_W-1:0] cyc_nx;
  logic [CNT_W-1:0] stl_nx;
  logic [CNT_W-1:0] ev_nx [N_EV];
  logic [CNT_W-1:0] rd_mux_p0;
  logic             finish;
  logic             budget_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != '1))
      return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    cyc_nx = sat_inc(cyc_q, 1'b1);
    stl_nx = sat_inc(stl_q, bus.stall);
    for (int k = 0; k < N_EV; k++)
      ev_nx[k] = sat_inc(ev_q[k], bus.ev[k]);
    finish     = bus.we && (bus.daddr == FINISH_ADDR);
    // A saturated counter never wraps to 0, so a zero budget never fires.
    budget_hit = (cyc_nx == BUDGET);
  end

  always_comb begin
    rd_mux_p0 = '0;
    if (rd_sel == SEL_W'(0))
      rd_mux_p0 = cyc_q;
    else if (rd_sel == SEL_W'(1))
      rd_mux_p0 = stl_q;
    else
      for (int k = 0; k < N_EV; k++)
        if (int'(rd_sel) == k + 2)
          rd_mux_p0 = ev_q[k];
  end

  // Stage boundary: counters, run state and registered readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      cyc_q      <= '0;
      stl_q      <= '0;
      for (int k = 0; k < N_EV; k++)
        ev_q[k] <= '0;
      result     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      done_pulse <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_data    <= rd_mux_p0;
      done_pulse <= 1'b0;
      if (clr) begin
        state   <= S_RUN;
        cyc_q   <= '0;
        stl_q   <= '0;
        for (int k = 0; k < N_EV; k++)
          ev_q[k] <= '0;
        result  <= '0;
        done    <= 1'b0;
        timeout <= 1'b0;
      end else if (state == S_RUN) begin
        cyc_q <= cyc_nx;
        stl_q <= stl_nx;
        for (int k = 0; k < N_EV; k++)
          ev_q[k] <= ev_nx[k];
        if (finish) begin
          state      <= S_DONE;
          result     <= bus.wdata;
          done       <= 1'b1;
          done_pulse <= 1'b1;
        end else if (budget_hit) begin
          state      <= S_TIMEOUT;
          timeout    <= 1'b1;
          done_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_perf_mon.sv
// Bench for mips_perf_mon: three configurations share one stimulus stream and
// are checked each cycle against a per-configuration behavioural model.
module tb_mips_perf_mon;

  localparam int N_EV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  ev = '0;
  logic [31:0] daddr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  rd_sel = '0;

  logic [31:0] rd_a, rd_b, res_a, res_b, res_c;
  logic [3:0]  rd_c;
  logic        done_a, done_b, done_c, to_a, to_b, to_c, p_a, p_b, p_c;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_perf_mon_if #(.DATA_W(32), .N_EV(N_EV)) bus_a ();
  mips_perf_mon_if #(.DATA_W(32), .N_EV(N_EV)) bus_b ();
  mips_perf_mon_if #(.DATA_W(32), .N_EV(N_EV)) bus_c ();

  assign bus_a.stall = stall; assign bus_a.ev = ev; assign bus_a.daddr = daddr;
  assign bus_a.we = we;       assign bus_a.wdata = wdata;
  assign bus_b.stall = stall; assign bus_b.ev = ev; assign bus_b.daddr = daddr;
  assign bus_b.we = we;       assign bus_b.wdata = wdata;
  assign bus_c.stall = stall; assign bus_c.ev = ev; assign bus_c.daddr = daddr;
  assign bus_c.we = we;       assign bus_c.wdata = wdata;

  mips_perf_mon #(.CNT_W(32), .N_EV(N_EV), .MAX_CYCLES(100000)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_sel(rd_sel), .bus(bus_a),
    .rd_data(rd_a), .done(done_a), .timeout(to_a), .done_pulse(p_a), .result(res_a));

  mips_perf_mon #(.CNT_W(32), .N_EV(N_EV), .MAX_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_sel(rd_sel), .bus(bus_b),
    .rd_data(rd_b), .done(done_b), .timeout(to_b), .done_pulse(p_b), .result(res_b));

  // Budget 0 is unreachable because counts saturate instead of wrapping.
  mips_perf_mon #(.CNT_W(4), .N_EV(N_EV), .MAX_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_sel(rd_sel), .bus(bus_c),
    .rd_data(rd_c), .done(done_c), .timeout(to_c), .done_pulse(p_c), .result(res_c));

  // Reference model: 0 = RUN, 1 = DONE, 2 = TIMEOUT
  longint m_lim [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  longint m_bud [3] = '{64'd100000, 64'd16, 64'd0};
  longint m_cyc [3];
  longint m_stl [3];
  longint m_ev  [3][N_EV];
  longint m_res [3];
  longint m_rd  [3];
  int     m_st  [3];
  bit     m_pls [3];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cyc[d] = 0; m_stl[d] = 0; m_res[d] = 0; m_rd[d] = 0;
      m_st[d] = 0;  m_pls[d] = 0;
      for (int k = 0; k < N_EV; k++) m_ev[d][k] = 0;
    end
  endtask

  function automatic longint bump(input longint v, input longint lim, input bit en);
    if (!en) return v;
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_step(input int d);
    int s;
    s = int'(rd_sel);
    if (s == 0)             m_rd[d] = m_cyc[d];
    else if (s == 1)        m_rd[d] = m_stl[d];
    else if (s < N_EV + 2)  m_rd[d] = m_ev[d][s-2];
    else                    m_rd[d] = 0;
    m_pls[d] = 0;
    if (clr) begin
      m_cyc[d] = 0; m_stl[d] = 0; m_res[d] = 0; m_st[d] = 0;
      for (int k = 0; k < N_EV; k++) m_ev[d][k] = 0;
    end else if (m_st[d] == 0) begin
      m_cyc[d] = bump(m_cyc[d], m_lim[d], 1'b1);
      m_stl[d] = bump(m_stl[d], m_lim[d], stall);
      for (int k = 0; k < N_EV; k++) m_ev[d][k] = bump(m_ev[d][k], m_lim[d], ev[k]);
      if (we && daddr == 32'd100) begin
        m_res[d] = longint'(wdata); m_st[d] = 1; m_pls[d] = 1;
      end else if (m_cyc[d] == m_bud[d]) begin
        m_st[d] = 2; m_pls[d] = 1;
      end
    end
  endtask

  task automatic check_dut(input int d, input longint rd, input bit dn, input bit to,
                           input bit p, input longint res);
    chk($sformatf("dut%0d_rd_data", d), rd, m_rd[d]);
    chk($sformatf("dut%0d_done", d), longint'(dn), longint'(m_st[d] == 1));
    chk($sformatf("dut%0d_timeout", d), longint'(to), longint'(m_st[d] == 2));
    chk($sformatf("dut%0d_done_pulse", d), longint'(p), longint'(m_pls[d]));
    chk($sformatf("dut%0d_result", d), res, m_res[d]);
  endtask

  task automatic check_all();
    check_dut(0, longint'(rd_a), done_a, to_a, p_a, longint'(res_a));
    check_dut(1, longint'(rd_b), done_b, to_b, p_b, longint'(res_b));
    check_dut(2, longint'(rd_c), done_c, to_c, p_c, longint'(res_c));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; ev = '0; we = 0; daddr = '0; wdata = '0; clr = 0;
  endtask

  task automatic restart();
    idle(); clr = 1; tick(); clr = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // Idle counting
    for (int i = 0; i < 10; i++) tick();
    rd_sel = 0; tick(); chk("idle_cycles", longint'(rd_a), 10);
    rd_sel = 1; tick(); chk("idle_stalls", longint'(rd_a), 0);
    chk("idle_done", longint'(done_a), 0);

    // Finish store on cycle 20
    restart();
    for (int c = 1; c <= 20; c++) begin
      stall = (c >= 3 && c <= 7);
      ev = (c == 10 || c == 12) ? 4'b0100 : 4'b0000;
      we = (c == 20); daddr = (c == 20) ? 32'd100 : 32'd0; wdata = 32'hDEADBEEF;
      tick();
    end
    chk("fin_done", longint'(done_a), 1);
    chk("fin_pulse", longint'(p_a), 1);
    chk("fin_result", longint'(res_a), 64'hDEADBEEF);
    idle();
    rd_sel = 0; tick(); chk("fin_cycles", longint'(rd_a), 20);
    chk("fin_pulse_gone", longint'(p_a), 0);
    rd_sel = 1; tick(); chk("fin_stalls", longint'(rd_a), 5);
    rd_sel = 4; tick(); chk("fin_ev2", longint'(rd_a), 2);
    for (int i = 0; i < 50; i++) begin
      stall = 1; ev = 4'hF; we = 1; daddr = 32'd100; wdata = $urandom; rd_sel = 0;
      tick();
    end
    chk("frozen_cycles", longint'(rd_a), 20);
    chk("frozen_result", longint'(res_a), 64'hDEADBEEF);

    // Near-miss stores
    restart();
    we = 1; daddr = 32'd104; wdata = 32'h1234; tick();
    we = 0; daddr = 32'd100; tick();
    chk("nearmiss_done", longint'(done_a), 0);
    chk("nearmiss_result", longint'(res_a), 0);

    // Timeout on 16-cycle budget, then finish on cycle 16
    restart();
    for (int i = 0; i < 16; i++) tick();
    chk("to_timeout", longint'(to_b), 1);
    chk("to_pulse", longint'(p_b), 1);
    chk("to_result", longint'(res_b), 0);
    rd_sel = 0; tick(); chk("to_cycles", longint'(rd_b), 16);
    restart();
    for (int c = 1; c <= 16; c++) begin
      we = (c == 16); daddr = 32'd100; wdata = 32'hA5A5_0016; tick();
    end
    chk("tie_done", longint'(done_b), 1);
    chk("tie_timeout", longint'(to_b), 0);
    idle();

    // Saturation of 4-bit counters
    restart();
    stall = 1;
    for (int i = 0; i < 20; i++) tick();
    stall = 0; rd_sel = 1; tick();
    chk("sat_stalls", longint'(rd_c), 15);

    // clr while DONE, then clr together with a finish store
    restart();
    we = 1; daddr = 32'd100; wdata = 32'h55; tick();
    chk("pre_clr_done", longint'(done_a), 1);
    idle(); clr = 1; tick();
    chk("clr_done", longint'(done_a), 0);
    chk("clr_result", longint'(res_a), 0);
    clr = 0; tick(); tick();
    clr = 1; we = 1; daddr = 32'd100; wdata = 32'h77; tick();
    chk("clrfin_done", longint'(done_a), 0);
    chk("clrfin_result", longint'(res_a), 0);
    idle(); rd_sel = 0; tick(); tick();
    chk("clr_restart_cycles", longint'(rd_a), 1);

    // Asynchronous reset mid-run
    stall = 1; ev = 4'hF; tick(); tick();
    #3 rst_n = 0;
    #1 model_reset();
    check_all();
    @(negedge clk); rst_n = 1;

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      stall  = 1'($urandom);
      ev     = 4'($urandom);
      we     = 1'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    daddr = 32'd100;
        2:       daddr = 32'd104;
        default: daddr = $urandom;
      endcase
      wdata  = $urandom;
      rd_sel = 4'($urandom);
      clr    = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
